// File: rtl/im_arb_if.sv
// Bundle of the im_arb request/grant and memory-side signals.
// The arbiter uses the slave view; the CPU, loader and memory side uses the master view.
interface im_arb_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              fetch_req;
   logic [ADDR_W-1:0] fetch_addr;
   logic              fetch_gnt;
   logic              fetch_vld;
   logic [DATA_W-1:0] fetch_instr;

   logic              ld_req;
   logic [ADDR_W-1:0] ld_addr;
   logic [DATA_W-1:0] ld_data;
   logic              ld_gnt;
   logic              ld_err;

   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd_en;
   logic              mem_wr_en;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output fetch_req, fetch_addr, ld_req, ld_addr, ld_data, mem_rdata,
      input  fetch_gnt, fetch_vld, fetch_instr, ld_gnt, ld_err,
             mem_addr, mem_rd_en, mem_wr_en, mem_wdata
   );

   modport slave (
      input  fetch_req, fetch_addr, ld_req, ld_addr, ld_data, mem_rdata,
      output fetch_gnt, fetch_vld, fetch_instr, ld_gnt, ld_err,
             mem_addr, mem_rd_en, mem_wr_en, mem_wdata
   );
endinterface

// File: rtl/im_arb.sv
// Instruction-memory arbiter: one port shared by CPU fetches and a program loader.
// The loader wins by default; a starve counter forces a fetch grant after MAX_LD loader wins.
module im_arb #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16,
   parameter int DEPTH  = 16384,
   parameter int MAX_LD = 4
) (
   input logic   clk,
   input logic   rst,
   im_arb_if.slave bus
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FETCH = 2'd1;
   localparam logic [1:0] LOAD  = 2'd2;

   localparam int CNT_W = (MAX_LD > 0) ? $clog2(MAX_LD + 1) : 1;
   localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_LD);
   localparam logic [ADDR_W:0]  DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

   logic [1:0]        state;
   logic [1:0]        state_nxt;
   logic [CNT_W-1:0]  starve_cnt;
   logic [CNT_W-1:0]  starve_nxt;
   logic [DATA_W-1:0] instr_hold;
   logic              ld_err_q;
   logic              grant_fetch;
   logic              grant_ld;
   logic              ld_in_range;
   logic              fetch_vld_int;

   // Grant decision; reset masks every grant regardless of requests.
   always_comb begin
      grant_fetch = 1'b0;
      grant_ld    = 1'b0;
      ld_in_range = ({1'b0, bus.ld_addr} < DEPTH_LIM);
      if (!rst) begin
         if (bus.fetch_req && (!bus.ld_req || (starve_cnt == MAX_CNT))) begin
            grant_fetch = 1'b1;
         end else if (bus.ld_req) begin
            grant_ld = 1'b1;
         end
      end
   end

   // Out-of-range loader writes are still granted but never reach memory.
   always_comb begin
      bus.fetch_gnt = grant_fetch;
      bus.ld_gnt    = grant_ld;
      bus.mem_rd_en = grant_fetch;
      bus.mem_wr_en = grant_ld && ld_in_range;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      if (grant_fetch) begin
         bus.mem_addr = bus.fetch_addr;
      end else if (grant_ld && ld_in_range) begin
         bus.mem_addr  = bus.ld_addr;
         bus.mem_wdata = bus.ld_data;
      end
   end

   always_comb begin
      state_nxt  = IDLE;
      starve_nxt = '0;
      if (grant_fetch) begin
         state_nxt = FETCH;
      end else if (grant_ld) begin
         state_nxt = LOAD;
      end
      if (bus.fetch_req && grant_ld) begin
         starve_nxt = (starve_cnt == MAX_CNT) ? starve_cnt : starve_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         starve_cnt <= '0;
         instr_hold <= '0;
         ld_err_q   <= 1'b0;
      end else begin
         state      <= state_nxt;
         starve_cnt <= starve_nxt;
         if (fetch_vld_int) begin
            instr_hold <= bus.mem_rdata;
         end
         if (grant_ld && !ld_in_range) begin
            ld_err_q <= 1'b1;
         end
      end
   end

   // FETCH state means last cycle granted a fetch, so read data is on mem_rdata now.
   assign fetch_vld_int   = (state == FETCH) && !rst;
   assign bus.fetch_vld   = fetch_vld_int;
   assign bus.fetch_instr = rst ? '0 : (fetch_vld_int ? bus.mem_rdata : instr_hold);
   assign bus.ld_err      = ld_err_q && !rst;

endmodule

// File: tb/tb_im_arb.sv
// Directed bench for im_arb: reset, single fetch, loader write, starvation pattern,
// back-to-back fetches, reset abort and sticky out-of-range loader error.
module tb_im_arb;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   logic [15:0] tb_mem [0:255];

   im_arb_if #(.ADDR_W(16), .DATA_W(16)) bus ();

   im_arb #(
      .ADDR_W(16),
      .DATA_W(16),
      .DEPTH (16384),
      .MAX_LD(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: read data appears the cycle after the read strobe.
   always @(posedge clk) begin
      if (bus.mem_rd_en) begin
         bus.mem_rdata <= tb_mem[bus.mem_addr[7:0]];
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.fetch_req  = 1'b0;
      bus.fetch_addr = 16'h0000;
      bus.ld_req     = 1'b0;
      bus.ld_addr    = 16'h0000;
      bus.ld_data    = 16'h0000;
   endtask

   task automatic test_reset();
      rst            = 1'b1;
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 16'h0010;
      bus.ld_req     = 1'b1;
      bus.ld_addr    = 16'h4000;
      bus.ld_data    = 16'hFFFF;
      step();
      step();
      #2;
      total++;
      if ({bus.fetch_gnt, bus.ld_gnt, bus.mem_rd_en, bus.mem_wr_en} !== 4'b0000) begin
         bad++;
         $display("[TB] FAIL reset_strobes got=%b exp=0000",
                  {bus.fetch_gnt, bus.ld_gnt, bus.mem_rd_en, bus.mem_wr_en});
      end
      total++;
      if ({bus.fetch_vld, bus.ld_err} !== 2'b00 || bus.fetch_instr !== 16'h0000) begin
         bad++;
         $display("[TB] FAIL reset_regs got vld/err=%b instr=%h exp 00/0000",
                  {bus.fetch_vld, bus.ld_err}, bus.fetch_instr);
      end
      step();
      rst = 1'b0;
      idle_inputs();
      #2;
      total++;
      if ({bus.fetch_gnt, bus.ld_gnt, bus.mem_rd_en, bus.mem_wr_en} !== 4'b0000 ||
          bus.mem_addr !== 16'h0000 || bus.mem_wdata !== 16'h0000) begin
         bad++;
         $display("[TB] FAIL idle_outputs got strobes=%b addr=%h wdata=%h exp 0000/0000/0000",
                  {bus.fetch_gnt, bus.ld_gnt, bus.mem_rd_en, bus.mem_wr_en},
                  bus.mem_addr, bus.mem_wdata);
      end
      step();
   endtask

   task automatic test_fetch();
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 16'h0010;
      #2;
      total++;
      if ({bus.fetch_gnt, bus.ld_gnt, bus.mem_rd_en, bus.mem_wr_en} !== 4'b1010 ||
          bus.mem_addr !== 16'h0010) begin
         bad++;
         $display("[TB] FAIL fetch_grant got strobes=%b addr=%h exp 1010/0010",
                  {bus.fetch_gnt, bus.ld_gnt, bus.mem_rd_en, bus.mem_wr_en}, bus.mem_addr);
      end
      step();
      idle_inputs();
      #2;
      total++;
      if (bus.fetch_vld !== 1'b1 || bus.fetch_instr !== 16'hA5A5) begin
         bad++;
         $display("[TB] FAIL fetch_data got vld=%b instr=%h exp 1/a5a5",
                  bus.fetch_vld, bus.fetch_instr);
      end
      step();
      #2;
      total++;
      if (bus.fetch_vld !== 1'b0 || bus.fetch_instr !== 16'hA5A5) begin
         bad++;
         $display("[TB] FAIL fetch_hold got vld=%b instr=%h exp 0/a5a5",
                  bus.fetch_vld, bus.fetch_instr);
      end
      step();
   endtask

   task automatic test_load();
      bus.ld_req  = 1'b1;
      bus.ld_addr = 16'h0003;
      bus.ld_data = 16'h1234;
      #2;
      total++;
      if ({bus.fetch_gnt, bus.ld_gnt, bus.mem_rd_en, bus.mem_wr_en} !== 4'b0101 ||
          bus.mem_addr !== 16'h0003 || bus.mem_wdata !== 16'h1234) begin
         bad++;
         $display("[TB] FAIL load_write got strobes=%b addr=%h wdata=%h exp 0101/0003/1234",
                  {bus.fetch_gnt, bus.ld_gnt, bus.mem_rd_en, bus.mem_wr_en},
                  bus.mem_addr, bus.mem_wdata);
      end
      step();
      idle_inputs();
      #2;
      total++;
      if (dut.starve_cnt !== 3'd0 || dut.state !== 2'd2) begin
         bad++;
         $display("[TB] FAIL load_state got cnt=%0d state=%0d exp 0/2",
                  dut.starve_cnt, dut.state);
      end
      step();
   endtask

   task automatic test_starve();
      logic [9:0] exp_f;
      exp_f = 10'b10_0001_0000;
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 16'h0010;
      bus.ld_req     = 1'b1;
      bus.ld_addr    = 16'h0020;
      bus.ld_data    = 16'h5555;
      for (int i = 0; i < 10; i++) begin
         #2;
         total++;
         if (bus.fetch_gnt !== exp_f[i] || bus.ld_gnt !== !exp_f[i]) begin
            bad++;
            $display("[TB] FAIL starve_cycle%0d got f=%b l=%b exp f=%b l=%b",
                     i, bus.fetch_gnt, bus.ld_gnt, exp_f[i], !exp_f[i]);
         end
         step();
      end
      idle_inputs();
      step();
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i <= 8; i++) begin
         if (i < 8) begin
            bus.fetch_req  = 1'b1;
            bus.fetch_addr = 16'(i);
         end else begin
            bus.fetch_req  = 1'b0;
         end
         #2;
         if (i < 8) begin
            total++;
            if (bus.fetch_gnt !== 1'b1 || bus.mem_addr !== 16'(i)) begin
               bad++;
               $display("[TB] FAIL b2b_grant%0d got gnt=%b addr=%h exp 1/%h",
                        i, bus.fetch_gnt, bus.mem_addr, 16'(i));
            end
         end
         if (i > 0) begin
            total++;
            if (bus.fetch_vld !== 1'b1 || bus.fetch_instr !== (16'hC000 + 16'(i - 1))) begin
               bad++;
               $display("[TB] FAIL b2b_data%0d got vld=%b instr=%h exp 1/%h",
                        i, bus.fetch_vld, bus.fetch_instr, 16'hC000 + 16'(i - 1));
            end
         end
         step();
      end
      idle_inputs();
      step();
   endtask

   task automatic test_reset_abort();
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 16'h0002;
      #2;
      total++;
      if (bus.fetch_gnt !== 1'b1) begin
         bad++;
         $display("[TB] FAIL abort_grant got=%b exp=1", bus.fetch_gnt);
      end
      step();
      rst = 1'b1;
      #2;
      total++;
      if (bus.fetch_gnt !== 1'b0 || bus.fetch_vld !== 1'b0) begin
         bad++;
         $display("[TB] FAIL abort_in_reset got gnt=%b vld=%b exp 0/0",
                  bus.fetch_gnt, bus.fetch_vld);
      end
      step();
      rst = 1'b0;
      idle_inputs();
      #2;
      total++;
      if (bus.fetch_vld !== 1'b0 || bus.fetch_instr !== 16'h0000 || dut.state !== 2'd0) begin
         bad++;
         $display("[TB] FAIL abort_after got vld=%b instr=%h state=%0d exp 0/0000/0",
                  bus.fetch_vld, bus.fetch_instr, dut.state);
      end
      step();
   endtask

   task automatic test_ld_err();
      bus.ld_req  = 1'b1;
      bus.ld_addr = 16'h3FFF;
      bus.ld_data = 16'hBEEF;
      #2;
      total++;
      if (bus.ld_gnt !== 1'b1 || bus.mem_wr_en !== 1'b1 || bus.mem_addr !== 16'h3FFF) begin
         bad++;
         $display("[TB] FAIL last_word got gnt=%b wr=%b addr=%h exp 1/1/3fff",
                  bus.ld_gnt, bus.mem_wr_en, bus.mem_addr);
      end
      step();
      bus.ld_addr = 16'h4000;
      #2;
      total++;
      if (bus.ld_err !== 1'b0 || bus.ld_gnt !== 1'b1 || bus.mem_wr_en !== 1'b0) begin
         bad++;
         $display("[TB] FAIL out_of_range got err=%b gnt=%b wr=%b exp 0/1/0",
                  bus.ld_err, bus.ld_gnt, bus.mem_wr_en);
      end
      step();
      idle_inputs();
      #2;
      total++;
      if (bus.ld_err !== 1'b1) begin
         bad++;
         $display("[TB] FAIL err_set got=%b exp=1", bus.ld_err);
      end
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 16'h0001;
      for (int i = 0; i < 3; i++) begin
         step();
      end
      idle_inputs();
      #2;
      total++;
      if (bus.ld_err !== 1'b1) begin
         bad++;
         $display("[TB] FAIL err_sticky got=%b exp=1", bus.ld_err);
      end
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      #2;
      total++;
      if (bus.ld_err !== 1'b0) begin
         bad++;
         $display("[TB] FAIL err_cleared got=%b exp=0", bus.ld_err);
      end
      step();
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      idle_inputs();
      for (int i = 0; i < 256; i++) begin
         tb_mem[i] = 16'hC000 + 16'(i);
      end
      tb_mem[16] = 16'hA5A5;
      $display("[TB] im_arb directed run");
      test_reset();
      test_fetch();
      test_load();
      test_starve();
      test_back_to_back();
      test_reset_abort();
      test_ld_err();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/im_arb.md
IM_ARB -- requirements
Module: im_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, memory address width.
REQ-002 SHALL have parameter DATA_W, default 16, instruction width.
REQ-003 SHALL have parameter DEPTH, default 16384, number of valid memory words.
REQ-004 SHALL have parameter MAX_LD, default 4, max consecutive loader grants while fetch waits.
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port fetch_req  input  1  CPU fetch request, held until granted.
REQ-008 SHALL have port fetch_addr  input  ADDR_W  CPU fetch address.
REQ-009 SHALL have port fetch_gnt  output  1  fetch accepted this cycle.
REQ-010 SHALL have port fetch_vld  output  1  fetch_instr valid, one cycle after fetch_gnt.
REQ-011 SHALL have port fetch_instr  output  DATA_W  returned instruction.
REQ-012 SHALL have port ld_req  input  1  loader write request, held until granted.
REQ-013 SHALL have port ld_addr  input  ADDR_W  loader write address.
REQ-014 SHALL have port ld_data  input  DATA_W  loader write data.
REQ-015 SHALL have port ld_gnt  output  1  loader write accepted this cycle.
REQ-016 SHALL have port ld_err  output  1  sticky: loader write to address >= DEPTH.
REQ-017 SHALL have port mem_addr  output  ADDR_W  memory address.
REQ-018 SHALL have port mem_rd_en  output  1  memory read strobe.
REQ-019 SHALL have port mem_wr_en  output  1  memory write strobe.
REQ-020 SHALL have port mem_wdata  output  DATA_W  memory write data.
REQ-021 SHALL have port mem_rdata  input  DATA_W  memory read data, valid the cycle after mem_rd_en.

Function
REQ-022 SHALL implement states IDLE, FETCH, LOAD; state is the owner of the previous granted cycle (IDLE = none).
REQ-023 SHALL grant at most one requester per cycle; fetch_gnt and ld_gnt never both 1.
REQ-024 SHALL assert grant, mem strobes, mem_addr and mem_wdata combinationally in the cycle of the request decision.
REQ-025 SHALL give priority to ld_req over fetch_req, except when starve count = MAX_LD and fetch_req = 1, then grant fetch.
REQ-026 SHALL keep starve count (width ceil(log2(MAX_LD+1))): +1 per ld_gnt while fetch_req = 1, cleared on fetch_gnt or when fetch_req = 0; saturates at MAX_LD.
REQ-027 SHALL on fetch_gnt drive mem_rd_en = 1, mem_addr = fetch_addr, mem_wr_en = 0; next state FETCH.
REQ-028 SHALL on ld_gnt with ld_addr < DEPTH drive mem_wr_en = 1, mem_addr = ld_addr, mem_wdata = ld_data; next state LOAD.
REQ-029 SHALL on ld_req with ld_addr >= DEPTH still assert ld_gnt, suppress mem_wr_en, set ld_err; next state LOAD.
REQ-030 SHALL with no request drive all strobes 0, grants 0; next state IDLE; counter cleared.
REQ-031 SHALL register fetch_vld = previous-cycle fetch_gnt; fetch_instr = mem_rdata when fetch_vld, else hold last value.
REQ-032 SHALL support back-to-back fetch grants (one instruction per cycle throughput, 1-cycle latency).
REQ-033 SHALL drive mem_addr = 0 and mem_wdata = 0 when no grant.
REQ-034 SHALL clear ld_err only on rst.

Reset
REQ-035 SHALL while rst = 1 force state IDLE, starve count 0, fetch_vld 0, fetch_instr 0, ld_err 0, and all grants/strobes 0 regardless of requests.
REQ-036 SHALL abort an in-flight fetch on rst: fetch_vld stays 0 in the cycle after reset even if fetch_gnt preceded it.

Verification
REQ-037 SHALL verify: fetch_req=1, fetch_addr=0x0010, mem_rdata=0xA5A5 next cycle -> fetch_gnt cycle N, fetch_vld=1 and fetch_instr=0xA5A5 cycle N+1.
REQ-038 SHALL verify: fetch_req and ld_req both held 1 for 10 cycles, MAX_LD=4 -> grant pattern L,L,L,L,F,L,L,L,L,F.
REQ-039 SHALL verify: ld_req=1, ld_addr=0x4000, DEPTH=16384 -> ld_gnt=1, mem_wr_en=0, ld_err=1 next cycle and stays 1 until rst.
REQ-040 SHALL verify: fetch_gnt in cycle N, rst=1 in cycle N+1 -> fetch_vld=0, fetch_instr=0, state IDLE in cycle N+2.
REQ-041 SHALL verify: fetch_req=1 for addresses 0..7 consecutive cycles -> 8 grants in 8 cycles, fetch_vld high 8 cycles, data in order.
REQ-042 SHALL verify: ld_req=1 ld_addr=0x0003 ld_data=0x1234, fetch_req=0 -> mem_wr_en=1, mem_addr=0x0003, mem_wdata=0x1234, starve count remains 0.
